chunked_adder: RTL and testbench

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder.sv | 141 ++++++++++++++
 tb/tb_chunked_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB slice first,
// with the slice carry held in a register between cycles.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               done_r;

    logic               ready_s;
    logic               accept_s;
    logic               last_s;
    logic [CHUNK-1:0]   sa_s;
    logic [CHUNK-1:0]   sb_s;
    logic [CHUNK:0]     slice_s;
    logic               msb_cin_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake decode from the current state
    always_comb begin
        ready_s  = 1'b0;
        accept_s = 1'b0;
        if (state_r == IDLE) begin
            ready_s  = 1'b1;
            accept_s = start;
        end else begin
            ready_s  = 1'b0;
            accept_s = 1'b0;
        end
    end

    // Current slice adder; the carry into the slice MSB is recovered for ovf
    always_comb begin
        sa_s      = a_r[cnt_r*CHUNK +: CHUNK];
        sb_s      = b_r[cnt_r*CHUNK +: CHUNK];
        slice_s   = {1'b0, sa_s} + {1'b0, sb_s} + {{CHUNK{1'b0}}, carry_r};
        msb_cin_s = sa_s[CHUNK-1] ^ sb_s[CHUNK-1] ^ slice_s[CHUNK-1];
        last_s    = (cnt_r == CW'(N - 1));
    end

    // Operand capture, per-slice accumulation and completion flags.
    // Subtraction stores ~b and ~cin so the BUSY path is a plain adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? ~cin : cin;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else if (state_r == BUSY) begin
            sum_r[cnt_r*CHUNK +: CHUNK] <= slice_s[CHUNK-1:0];
            carry_r <= slice_s[CHUNK];
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
                cout_r <= slice_s[CHUNK];
                ovf_r  <= msb_cin_s ^ slice_s[CHUNK];
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign ready = ready_s;
    assign sum   = sum_r;
    assign cout  = cout_r;
    assign ovf   = ovf_r;
    assign done  = done_r;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder in three shapes (16/4, 8/8, 8/1) against an
// arithmetic reference model checked every cycle, plus literal directed cases.
module tb_chunked_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st [3];
    logic [15:0] aa [3];
    logic [15:0] bb [3];
    logic        ci [3];
    logic        sb [3];
    logic [15:0] sm0;
    logic [7:0]  sm1;
    logic [7:0]  sm2;
    logic        co [3];
    logic        ov [3];
    logic        dn [3];
    logic        rd [3];

    int checks = 0;
    int errors = 0;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .ready(rd[0]),
        .a(aa[0]), .b(bb[0]), .cin(ci[0]), .sub(sb[0]),
        .sum(sm0), .cout(co[0]), .ovf(ov[0]), .done(dn[0])
    );
    chunked_adder #(.WIDTH(8), .CHUNK(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .ready(rd[1]),
        .a(aa[1][7:0]), .b(bb[1][7:0]), .cin(ci[1]), .sub(sb[1]),
        .sum(sm1), .cout(co[1]), .ovf(ov[1]), .done(dn[1])
    );
    chunked_adder #(.WIDTH(8), .CHUNK(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .ready(rd[2]),
        .a(aa[2][7:0]), .b(bb[2][7:0]), .cin(ci[2]), .sub(sb[2]),
        .sum(sm2), .cout(co[2]), .ovf(ov[2]), .done(dn[2])
    );

    function automatic int wof(int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic int nof(int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [15:0] get_sum(int d);
        case (d)
            0:       return sm0;
            1:       return {8'h00, sm1};
            default: return {8'h00, sm2};
        endcase
    endfunction

    // Reference: {ovf, cout, sum} from whole-word arithmetic at width w
    function automatic logic [17:0] ref_op(int w, logic [15:0] x, logic [15:0] y,
                                           logic c, logic s);
        logic [16:0] m;
        logic [16:0] full;
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] r;
        logic        cc;
        logic        o;
        m    = (17'd1 << w) - 17'd1;
        xx   = x & m[15:0];
        yy   = (s ? ~y : y) & m[15:0];
        cc   = s ? ~c : c;
        full = {1'b0, xx} + {1'b0, yy} + {16'd0, cc};
        r    = full[15:0] & m[15:0];
        o    = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
        return {o, full[w], r};
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Model state per DUT: cycles left busy, pending and held results
    int          busy [3];
    logic [17:0] pend [3];
    logic [17:0] hold [3];
    logic        exp_done [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            busy[d] = 0; pend[d] = 18'd0; hold[d] = 18'd0; exp_done[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                exp_done[d] = 1'b0;
                if (!rst_n) begin
                    busy[d] = 0; hold[d] = 18'd0;
                end else if (busy[d] == 0) begin
                    if (st[d]) begin
                        pend[d] = ref_op(wof(d), aa[d], bb[d], ci[d], sb[d]);
                        busy[d] = nof(d);
                    end
                end else begin
                    busy[d]--;
                    if (busy[d] == 0) begin
                        hold[d]     = pend[d];
                        exp_done[d] = 1'b1;
                    end
                end
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    busy[d] = 0; hold[d] = 18'd0; exp_done[d] = 1'b0;
                end
                chk($sformatf("ready%0d", d), 16'(rd[d]), 16'(busy[d] == 0));
                chk($sformatf("done%0d", d), 16'(dn[d]), 16'(exp_done[d]));
                if (busy[d] == 0) begin
                    chk($sformatf("sum%0d", d), get_sum(d), hold[d][15:0]);
                    chk($sformatf("cout%0d", d), 16'(co[d]), 16'(hold[d][16]));
                    chk($sformatf("ovf%0d", d), 16'(ov[d]), 16'(hold[d][17]));
                end
            end
        end
    end

    // One operation from a ready DUT; returns in the done cycle.
    // With poke set, a second start with other operands is issued mid-operation.
    task automatic run_op(int d, logic [15:0] x, logic [15:0] y, logic c, logic s,
                          logic [15:0] es, logic ec, logic eo, int elat, bit poke,
                          string nm);
        int lat;
        lat = 0;
        aa[d] = x; bb[d] = y; ci[d] = c; sb[d] = s; st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        while (lat < 40) begin
            if (poke && lat == 1) begin
                aa[d] = ~x; bb[d] = 16'h1234; ci[d] = ~c; sb[d] = ~s; st[d] = 1'b1;
            end
            if (poke && lat == 2) st[d] = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (dn[d]) break;
        end
        chk({nm, " latency"}, 16'(lat), 16'(elat));
        chk({nm, " sum"}, get_sum(d), es);
        chk({nm, " cout"}, 16'(co[d]), 16'(ec));
        chk({nm, " ovf"}, 16'(ov[d]), 16'(eo));
    endtask

    initial begin
        logic [17:0] r;
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic        s;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; aa[d] = 16'h0; bb[d] = 16'h0; ci[d] = 1'b0; sb[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 16'(rd[0]), 16'h0001);
        chk("reset done", 16'(dn[0]), 16'h0000);
        chk("reset sum", sm0, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4, 1'b0, "add_ff_01");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, 1'b0, "signed_ovf");
        run_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b0, "wrap");
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, 1'b0, "sub_borrow");
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, 1'b0, "sub_ovf");
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4, 1'b1, "start_busy");
        @(posedge clk); #1;

        // Abort two cycles into an operation
        aa[0] = 16'h1111; bb[0] = 16'h2222; ci[0] = 1'b0; sb[0] = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort sum", sm0, 16'h0000);
        chk("abort ready", 16'(rd[0]), 16'h0001);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort no done", 16'(dn[0]), 16'h0000);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0, 4, 1'b0, "after_reset");

        run_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, "n1_ff_01");
        run_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8, 1'b0, "n8_ff_01");

        for (int i = 0; i < 100; i++) begin
            x = 16'($urandom); y = 16'($urandom);
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            r = ref_op(16, x, y, c, s);
            run_op(0, x, y, c, s, r[15:0], r[16], r[17], 4, 1'($urandom_range(0, 1)), "rand16");
        end
        for (int i = 0; i < 100; i++) begin
            x = {8'h00, 8'($urandom)}; y = {8'h00, 8'($urandom)};
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            r = ref_op(8, x, y, c, s);
            run_op(2, x, y, c, s, r[15:0], r[16], r[17], 8, 1'b0, "rand8_n8");
        end

        // 8-bit sweep on the single-slice DUT; start stays high so every
        // done cycle accepts the next operands
        @(posedge clk); #1;
        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = (4 - (xi % 4)) % 4; yi < 256; yi += 4) begin
                aa[1] = 16'(xi); bb[1] = 16'(yi);
                ci[1] = 1'($urandom_range(0, 1)); sb[1] = 1'($urandom_range(0, 1));
                st[1] = 1'b1;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        st[1] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
